// File: rtl/ysyx_23060124_wbu_stage_pkg.sv
// Shared write-back stage constants and the decoded control-flag bundle.
// Default widths and reset PC live here so that EXU, WBU and PCU agree on them.
package ysyx_23060124_wbu_stage_pkg;

    localparam int          WBU_XLEN     = 32;
    localparam logic [31:0] WBU_RESET_PC = 32'h8000_0000;
    localparam int          WBU_RD_W     = 5;
    localparam int          WBU_CNT_W    = 64;

    // Slot occupancy.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    typedef struct packed {
        logic wen;
        logic brch;
        logic jal;
        logic jalr;
        logic csrr;
        logic mret;
        logic ecall;
    } wbu_flags_t;

endpackage

// File: rtl/ysyx_23060124_wbu_npc.sv
// Combinational next-PC selection for the held write-back entry.
// A taken jal/jalr/branch whose target is not word aligned is diverted to mtvec.
module ysyx_23060124_wbu_npc #(
    parameter int XLEN = 32
) (
    input  logic            jal,
    input  logic            jalr,
    input  logic            brch,
    input  logic            ecall,
    input  logic            mret,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] res,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] npc,
    output logic [XLEN-1:0] pc_seq,
    output logic            misalign
);

    logic [XLEN-1:0] pc_rel;
    logic [XLEN-1:0] target;
    logic            taken;

    assign pc_seq = pc + XLEN'(4);
    assign pc_rel = pc + imm;

    always_comb begin
        target = pc_rel;
        taken  = 1'b0;
        if (jal) begin
            taken = 1'b1;
        end else if (jalr) begin
            target = (rs1 + imm) & {{(XLEN-1){1'b1}}, 1'b0};
            taken  = 1'b1;
        end else if (brch && (res != '0)) begin
            taken = 1'b1;
        end
    end

    assign misalign = taken && (target[1:0] != 2'b00);

    always_comb begin
        npc = pc_seq;
        if (taken) begin
            npc = misalign ? mtvec : target;
        end else if (ecall) begin
            npc = mtvec;
        end else if (mret) begin
            npc = mepc;
        end
    end

endmodule

// File: rtl/ysyx_23060124_wbu_stage.sv
// Registered one-entry write-back slot between EXU and PCU/regfile; a new entry
// can replace the committing one in the same cycle, so throughput is 1 instr/cycle.
module ysyx_23060124_wbu_stage
    import ysyx_23060124_wbu_stage_pkg::*;
#(
    parameter int              XLEN     = WBU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(WBU_RESET_PC),
    parameter int              RD_W     = WBU_RD_W,
    parameter int              CNT_W    = WBU_CNT_W
) (
    input  logic             clk,
    input  logic             i_rst_wbu,
    input  logic             i_pre_valid,
    output logic             o_pre_ready,
    input  logic             i_wen,
    input  logic             i_brch,
    input  logic             i_jal,
    input  logic             i_jalr,
    input  logic             i_csrr,
    input  logic             i_mret,
    input  logic             i_ecall,
    input  logic [RD_W-1:0]  i_rd,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_rs1,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [XLEN-1:0]  i_res,
    input  logic [XLEN-1:0]  i_mepc,
    input  logic [XLEN-1:0]  i_mtvec,
    input  logic [XLEN-1:0]  i_csr_rdata,
    output logic [XLEN-1:0]  o_pc_next,
    output logic             o_pc_valid,
    input  logic             i_pc_ready,
    output logic [RD_W-1:0]  o_rd_waddr,
    output logic [XLEN-1:0]  o_rd_wdata,
    output logic             o_wbu_wen,
    output logic [XLEN-1:0]  o_csr_wdata,
    output logic             o_csr_wen,
    output logic             o_misalign,
    output logic [CNT_W-1:0] o_retire_cnt
);

    logic [0:0]      state;
    wbu_flags_t      flags_q;
    logic [RD_W-1:0] rd_q;
    logic [XLEN-1:0] pc_q, rs1_q, imm_q, res_q, mepc_q, mtvec_q, csr_rdata_q;
    logic [CNT_W-1:0] retire_cnt;

    logic            commit;
    logic            capture;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] pc_seq;
    logic            misalign;

    assign commit      = (state == ST_FULL) && i_pc_ready;
    assign o_pre_ready = (state == ST_EMPTY) || commit;
    assign capture     = i_pre_valid && o_pre_ready;

    always_ff @(posedge clk or posedge i_rst_wbu) begin
        if (i_rst_wbu) begin
            state <= ST_EMPTY;
        end else if (capture) begin
            state <= ST_FULL;
        end else if (commit) begin
            state <= ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge i_rst_wbu) begin
        if (i_rst_wbu) begin
            flags_q     <= '0;
            rd_q        <= '0;
            pc_q        <= '0;
            rs1_q       <= '0;
            imm_q       <= '0;
            res_q       <= '0;
            mepc_q      <= '0;
            mtvec_q     <= '0;
            csr_rdata_q <= '0;
        end else if (capture) begin
            flags_q     <= '{wen: i_wen, brch: i_brch, jal: i_jal, jalr: i_jalr,
                             csrr: i_csrr, mret: i_mret, ecall: i_ecall};
            rd_q        <= i_rd;
            pc_q        <= i_pc;
            rs1_q       <= i_rs1;
            imm_q       <= i_imm;
            res_q       <= i_res;
            mepc_q      <= i_mepc;
            mtvec_q     <= i_mtvec;
            csr_rdata_q <= i_csr_rdata;
        end
    end

    always_ff @(posedge clk or posedge i_rst_wbu) begin
        if (i_rst_wbu) begin
            retire_cnt <= '0;
        end else if (commit) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    ysyx_23060124_wbu_npc #(.XLEN(XLEN)) u_npc (
        .jal      (flags_q.jal),
        .jalr     (flags_q.jalr),
        .brch     (flags_q.brch),
        .ecall    (flags_q.ecall),
        .mret     (flags_q.mret),
        .pc       (pc_q),
        .rs1      (rs1_q),
        .imm      (imm_q),
        .res      (res_q),
        .mepc     (mepc_q),
        .mtvec    (mtvec_q),
        .npc      (npc),
        .pc_seq   (pc_seq),
        .misalign (misalign)
    );

    // Strobes fire only in the commit cycle; a misaligned target suppresses all writes.
    assign o_pc_valid   = (state == ST_FULL);
    assign o_pc_next    = o_pc_valid ? npc : RESET_PC;
    assign o_rd_waddr   = rd_q;
    assign o_rd_wdata   = (flags_q.jal || flags_q.jalr) ? pc_seq :
                          flags_q.csrr ? csr_rdata_q : res_q;
    assign o_wbu_wen    = commit && flags_q.wen && (rd_q != '0) && !misalign;
    assign o_csr_wdata  = res_q;
    assign o_csr_wen    = commit && flags_q.csrr && !misalign;
    assign o_misalign   = commit && misalign;
    assign o_retire_cnt = retire_cnt;

endmodule

// File: tb/tb_ysyx_23060124_wbu_stage.sv
// Bench for the write-back slot: directed cases with literal expectations plus
// randomized traffic compared every cycle against a queue-based slot model.
module tb_ysyx_23060124_wbu_stage;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct {
        logic        wen, brch, jal, jalr, csrr, mret, ecall;
        logic [4:0]  rd;
        logic [31:0] pc, rs1, imm, res, mepc, mtvec, csr_rdata;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pre_valid = 1'b0;
    logic        pc_ready = 1'b0;
    ent_t        cur;

    logic        o_pre_ready, o_pc_valid, o_wbu_wen, o_csr_wen, o_misalign;
    logic [31:0] o_pc_next, o_rd_wdata, o_csr_wdata;
    logic [4:0]  o_rd_waddr;
    logic [63:0] o_retire_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_23060124_wbu_stage dut (
        .clk          (clk),
        .i_rst_wbu    (rst),
        .i_pre_valid  (pre_valid),
        .o_pre_ready  (o_pre_ready),
        .i_wen        (cur.wen),
        .i_brch       (cur.brch),
        .i_jal        (cur.jal),
        .i_jalr       (cur.jalr),
        .i_csrr       (cur.csrr),
        .i_mret       (cur.mret),
        .i_ecall      (cur.ecall),
        .i_rd         (cur.rd),
        .i_pc         (cur.pc),
        .i_rs1        (cur.rs1),
        .i_imm        (cur.imm),
        .i_res        (cur.res),
        .i_mepc       (cur.mepc),
        .i_mtvec      (cur.mtvec),
        .i_csr_rdata  (cur.csr_rdata),
        .o_pc_next    (o_pc_next),
        .o_pc_valid   (o_pc_valid),
        .i_pc_ready   (pc_ready),
        .o_rd_waddr   (o_rd_waddr),
        .o_rd_wdata   (o_rd_wdata),
        .o_wbu_wen    (o_wbu_wen),
        .o_csr_wdata  (o_csr_wdata),
        .o_csr_wen    (o_csr_wen),
        .o_misalign   (o_misalign),
        .o_retire_cnt (o_retire_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t idle();
        ent_t z;
        z = '{default: '0};
        return z;
    endfunction

    // Architectural next-PC rules, straight from the instruction semantics.
    task automatic model_npc(input ent_t e, output logic [31:0] n, output bit mis);
        logic [31:0] t;
        bit taken;
        taken = 1'b1;
        t = 32'h0;
        if (e.jal)                         t = e.pc + e.imm;
        else if (e.jalr)                   t = (e.rs1 + e.imm) & 32'hFFFF_FFFE;
        else if (e.brch && e.res != 32'h0) t = e.pc + e.imm;
        else                               taken = 1'b0;
        mis = taken && (t % 4 != 0);
        if (taken)        n = mis ? e.mtvec : t;
        else if (e.ecall) n = e.mtvec;
        else if (e.mret)  n = e.mepc;
        else              n = e.pc + 32'd4;
    endtask

    // Reference: the slot is a queue holding at most one entry.
    ent_t        slot[$];
    logic [63:0] m_cnt = 64'd0;

    always @(posedge clk or posedge rst) begin : mdl
        if (rst) begin
            slot.delete();
            m_cnt = 64'd0;
        end else begin
            if (slot.size() != 0 && pc_ready) begin
                void'(slot.pop_front());
                m_cnt = m_cnt + 64'd1;
            end
            if (pre_valid && slot.size() == 0) slot.push_back(cur);
        end
    end

    always @(negedge clk) begin : cmp
        ent_t        e;
        bit          full, c, mis;
        logic [31:0] n, wd;
        full = (slot.size() != 0);
        e = full ? slot[0] : idle();
        c = full && pc_ready;
        if (full) model_npc(e, n, mis);
        else begin n = RST_PC; mis = 1'b0; end
        wd = (e.jal || e.jalr) ? e.pc + 32'd4 : (e.csrr ? e.csr_rdata : e.res);
        chk("m_pc_valid", o_pc_valid, full);
        chk("m_pre_ready", o_pre_ready, !full || pc_ready);
        chk("m_retire_cnt", o_retire_cnt, m_cnt);
        chk("m_pc_next", o_pc_next, n);
        chk("m_wbu_wen", o_wbu_wen, c && e.wen && e.rd != 5'd0 && !mis);
        chk("m_csr_wen", o_csr_wen, c && e.csrr && !mis);
        chk("m_misalign", o_misalign, c && mis);
        if (full) begin
            chk("m_rd_waddr", o_rd_waddr, e.rd);
            chk("m_rd_wdata", o_rd_wdata, wd);
            chk("m_csr_wdata", o_csr_wdata, e.res);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one entry for a single cycle, then sample it while it is held.
    task automatic present(input ent_t e);
        cur = e;
        pre_valid = 1'b1;
        tick();
        cur = idle();
        pre_valid = 1'b0;
        @(negedge clk);
    endtask

    function automatic ent_t rand_ent();
        ent_t e;
        logic [31:0] r;
        e = idle();
        r = $urandom;
        case ($urandom_range(0, 6))
            0: e.jal = 1'b1;
            1: e.jalr = 1'b1;
            2: e.brch = 1'b1;
            3: e.ecall = 1'b1;
            4: e.mret = 1'b1;
            5: e.csrr = 1'b1;
            default: ;
        endcase
        if (r[31:30] == 2'b00) begin
            e.jal = r[0]; e.jalr = r[1]; e.brch = r[2]; e.ecall = r[3];
            e.mret = r[4]; e.csrr = r[5];
        end
        e.wen = r[8];
        e.rd = 5'($urandom);
        e.pc = $urandom & 32'hFFFF_FFFC;
        e.imm = $urandom;
        if (r[9]) e.imm[1:0] = 2'b00;
        e.rs1 = $urandom;
        e.res = r[10] ? 32'h0 : $urandom;
        e.mepc = $urandom;
        e.mtvec = $urandom;
        e.csr_rdata = $urandom;
        return e;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        ent_t e, a, b;
        cur = idle();
        rst = 1'b1;

        // Reset state
        tick();
        chk("rst_pc_valid", o_pc_valid, 1'b0);
        chk("rst_pc_next", o_pc_next, 32'h8000_0000);
        chk("rst_cnt", o_retire_cnt, 64'd0);
        chk("rst_wbu_wen", o_wbu_wen, 1'b0);
        chk("rst_misalign", o_misalign, 1'b0);
        chk("rst_rd_wdata", o_rd_wdata, 32'h0);
        rst = 1'b0;
        pc_ready = 1'b1;

        // jal with link
        e = idle(); e.jal = 1'b1; e.wen = 1'b1; e.rd = 5'd1;
        e.pc = 32'h8000_0000; e.imm = 32'h10;
        present(e);
        chk("jal_pc_next", o_pc_next, 32'h8000_0010);
        chk("jal_rd_wdata", o_rd_wdata, 32'h8000_0004);
        chk("jal_wbu_wen", o_wbu_wen, 1'b1);
        tick();
        @(negedge clk);
        chk("jal_wen_drop", o_wbu_wen, 1'b0);
        chk("jal_cnt", o_retire_cnt, 64'd1);
        tick();

        // jalr clears bit 0; jal to a halfword target traps
        e = idle(); e.jalr = 1'b1; e.wen = 1'b1; e.rd = 5'd2;
        e.pc = 32'h8000_0004; e.rs1 = 32'h8000_0101; e.imm = 32'h0;
        present(e);
        chk("jalr_pc_next", o_pc_next, 32'h8000_0100);
        chk("jalr_misalign", o_misalign, 1'b0);
        chk("jalr_rd_wdata", o_rd_wdata, 32'h8000_0008);
        tick();
        e = idle(); e.jal = 1'b1; e.wen = 1'b1; e.rd = 5'd1;
        e.pc = 32'h8000_0000; e.imm = 32'h2; e.mtvec = 32'h8000_0200;
        present(e);
        chk("mis_flag", o_misalign, 1'b1);
        chk("mis_pc_next", o_pc_next, 32'h8000_0200);
        chk("mis_wbu_wen", o_wbu_wen, 1'b0);
        tick();
        @(negedge clk);
        chk("mis_cnt", o_retire_cnt, 64'd3);
        tick();

        // Reset while holding an entry discards it
        pc_ready = 1'b0;
        e = idle(); e.wen = 1'b1; e.rd = 5'd5; e.pc = 32'h8000_0010;
        present(e);
        chk("hold_valid", o_pc_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", o_pc_valid, 1'b0);
        chk("mid_rst_pc_next", o_pc_next, 32'h8000_0000);
        chk("mid_rst_cnt", o_retire_cnt, 64'd0);
        chk("mid_rst_wen", o_wbu_wen, 1'b0);
        pc_ready = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", o_pc_valid, 1'b0);
        chk("post_rst_wen", o_wbu_wen, 1'b0);
        tick();

        // Backpressure for three cycles, then back-to-back drain
        a = idle(); a.wen = 1'b1; a.rd = 5'd4; a.pc = 32'h8000_0020; a.res = 32'h77;
        b = idle(); b.jal = 1'b1; b.wen = 1'b1; b.rd = 5'd1;
        b.pc = 32'h8000_0030; b.imm = 32'h100;
        pc_ready = 1'b0;
        cur = a; pre_valid = 1'b1;
        tick();
        cur = b;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_pre_ready", o_pre_ready, 1'b0);
            chk("bp_pc_next", o_pc_next, 32'h8000_0024);
            chk("bp_rd_wdata", o_rd_wdata, 32'h77);
            tick();
        end
        pc_ready = 1'b1;
        @(negedge clk);
        chk("rel_pre_ready", o_pre_ready, 1'b1);
        chk("rel_wen_a", o_wbu_wen, 1'b1);
        chk("rel_cnt0", o_retire_cnt, 64'd0);
        tick();
        cur = idle(); pre_valid = 1'b0;
        @(negedge clk);
        chk("rel_b_valid", o_pc_valid, 1'b1);
        chk("rel_b_pc_next", o_pc_next, 32'h8000_0130);
        chk("rel_cnt1", o_retire_cnt, 64'd1);
        tick();
        @(negedge clk);
        chk("rel_cnt2", o_retire_cnt, 64'd2);
        chk("rel_empty", o_pc_valid, 1'b0);
        tick();

        // Branches and x0 writes
        e = idle(); e.brch = 1'b1; e.res = 32'h1; e.imm = 32'hFFFF_FFF8; e.pc = 32'h8000_0008;
        present(e);
        chk("beq_taken", o_pc_next, 32'h8000_0000);
        tick();
        e.res = 32'h0;
        present(e);
        chk("beq_not_taken", o_pc_next, 32'h8000_000C);
        tick();
        e = idle(); e.wen = 1'b1; e.rd = 5'd0; e.res = 32'h55; e.pc = 32'h8000_0100;
        present(e);
        chk("x0_commit", o_pc_valid, 1'b1);
        chk("x0_wbu_wen", o_wbu_wen, 1'b0);
        tick();

        // Traps and CSR access
        e = idle(); e.ecall = 1'b1; e.mtvec = 32'h8000_0200; e.pc = 32'h8000_0040;
        present(e);
        chk("ecall_pc_next", o_pc_next, 32'h8000_0200);
        tick();
        e = idle(); e.mret = 1'b1; e.mepc = 32'h8000_0044; e.pc = 32'h8000_0204;
        present(e);
        chk("mret_pc_next", o_pc_next, 32'h8000_0044);
        tick();
        e = idle(); e.csrr = 1'b1; e.wen = 1'b1; e.rd = 5'd3;
        e.csr_rdata = 32'h1234; e.res = 32'h5; e.pc = 32'h8000_0048;
        present(e);
        chk("csr_rd_wdata", o_rd_wdata, 32'h1234);
        chk("csr_wdata", o_csr_wdata, 32'h5);
        chk("csr_wen", o_csr_wen, 1'b1);
        chk("csr_wbu_wen", o_wbu_wen, 1'b1);
        tick();

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            if (rst) rst = 1'b0;
            pc_ready  = ($urandom_range(0, 3) != 0);
            pre_valid = ($urandom_range(0, 3) != 0);
            cur = rand_ent();
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        pre_valid = 1'b0;
        pc_ready = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
